// File: rtl/ines_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ines_loader
//  Purpose  : Configuration and fill stage for the cartridge mapper. Parses
//             the 16-byte iNES header from a byte stream, registers the
//             mapper configuration and masks, skips an optional 512-byte
//             trainer, then streams PRG ROM and CHR ROM contents out as write
//             strobes with 1-cycle latency. Raises loaded when the image is
//             complete, or error/err_code when the header is rejected.
//  Ports    : clk_cpu, rst            - clock, synchronous active-high reset
//             in_data/in_valid/in_ready - image byte stream handshake
//             wr_data, prg_we/prg_wr_addr, chr_we/chr_wr_addr - ROM fill
//             mapper_id, mirrorv, prg_ram, chr_ram, prg_mask, chr_mask,
//             prgram_mask             - decoded cartridge configuration
//             loaded, error, err_code - load status (sticky until rst)
//  Option   : `define INES_NES2_EN to decode NES 2.0 widened ROM sizes and
//             the PRG RAM size byte.
//  Revision : 1.0 - initial release
// ============================================================================
module ines_loader #(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 15,
  parameter int PRG_RAM_DEPTH = 13
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               wr_data,
  output logic                     prg_we,
  output logic [PRG_ROM_DEPTH-1:0] prg_wr_addr,
  output logic                     chr_we,
  output logic [CHR_ROM_DEPTH-1:0] chr_wr_addr,
  output logic [7:0]               mapper_id,
  output logic                     mirrorv,
  output logic                     prg_ram,
  output logic                     chr_ram,
  output logic [PRG_ROM_DEPTH-1:0] prg_mask,
  output logic [CHR_ROM_DEPTH-1:0] chr_mask,
  output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
  output logic                     loaded,
  output logic                     error,
  output logic [1:0]               err_code
);

  // Counter spans the larger ROM so a full-size section never wraps.
  localparam int CW = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH;

`ifdef INES_NES2_EN
  localparam int UW = 12;
`else
  localparam int UW = 8;
`endif

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_TRAIN = 3'd1;
  localparam logic [2:0] S_PRG   = 3'd2;
  localparam logic [2:0] S_CHR   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [CW-1:0] HDR_LAST   = CW'(15);
  localparam logic [CW-1:0] MAGIC_LEN  = CW'(4);
  localparam logic [CW-1:0] TRAIN_LAST = CW'(511);
  localparam logic [31:0]   PRG_MAX_UNITS = 32'd1 << (PRG_ROM_DEPTH - 14);
  localparam logic [31:0]   CHR_MAX_UNITS = 32'd1 << (CHR_ROM_DEPTH - 13);

  // Smallest e with 2^e >= u (0 for u <= 1).
  function automatic int f_ceil_log2(input logic [UW-1:0] u);
    int r;
    r = 0;
    for (int i = 0; i < UW + 1; i++) begin
      if ((32'd1 << i) < 32'(u)) r = i + 1;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               prg_lo_q, prg_lo_d;
  logic [7:0]               chr_lo_q, chr_lo_d;
  logic                     mir_q, mir_d;
  logic                     ram_q, ram_d;
  logic                     trn_q, trn_d;
  logic [3:0]               map_lo_q, map_lo_d;
  logic [3:0]               map_hi_q, map_hi_d;
`ifdef INES_NES2_EN
  logic                     nes2_q, nes2_d;
  logic [7:0]               b9_q, b9_d;
  logic                     b10_nz_q, b10_nz_d;
`endif
  logic [7:0]               wr_data_q, wr_data_d;
  logic                     prg_we_q, prg_we_d;
  logic                     chr_we_q, chr_we_d;
  logic [PRG_ROM_DEPTH-1:0] prg_wr_addr_q, prg_wr_addr_d;
  logic [CHR_ROM_DEPTH-1:0] chr_wr_addr_q, chr_wr_addr_d;
  logic [7:0]               mapper_id_q, mapper_id_d;
  logic                     mirrorv_q, mirrorv_d;
  logic                     prg_ram_q, prg_ram_d;
  logic                     chr_ram_q, chr_ram_d;
  logic [PRG_ROM_DEPTH-1:0] prg_mask_q, prg_mask_d;
  logic [CHR_ROM_DEPTH-1:0] chr_mask_q, chr_mask_d;
  logic [PRG_RAM_DEPTH-1:0] prgram_mask_q, prgram_mask_d;
  logic                     loaded_q, loaded_d;
  logic                     error_q, error_d;
  logic [1:0]               err_code_q, err_code_d;

  // --------------------------------------------------------------------------
  // Derived header values
  // --------------------------------------------------------------------------
  logic [UW-1:0]            w_prg_units;
  logic [UW-1:0]            w_chr_units;
  logic                     w_prg_exp_bad;
  logic                     w_chr_exp_bad;
  logic                     w_prg_ram_ext;
  logic                     w_accept;
  logic [7:0]               w_magic;
  logic                     w_magic_bad;
  logic                     w_hdr_last;
  logic                     w_prg_bad;
  logic                     w_chr_bad;
  logic                     w_prg_last;
  logic                     w_chr_last;
  logic [PRG_ROM_DEPTH-1:0] w_prg_mask;
  logic [CHR_ROM_DEPTH-1:0] w_chr_mask;

`ifdef INES_NES2_EN
  // NES 2.0 extends the unit counts with the nibbles of byte 9; a nibble of
  // 0xF selects the exponent-multiplier form, which this loader rejects.
  assign w_prg_units   = nes2_q ? {b9_q[3:0], prg_lo_q} : {4'h0, prg_lo_q};
  assign w_chr_units   = nes2_q ? {b9_q[7:4], chr_lo_q} : {4'h0, chr_lo_q};
  assign w_prg_exp_bad = nes2_q && (b9_q[3:0] == 4'hF);
  assign w_chr_exp_bad = nes2_q && (b9_q[7:4] == 4'hF);
  assign w_prg_ram_ext = nes2_q && b10_nz_q;
`else
  assign w_prg_units   = prg_lo_q;
  assign w_chr_units   = chr_lo_q;
  assign w_prg_exp_bad = 1'b0;
  assign w_chr_exp_bad = 1'b0;
  assign w_prg_ram_ext = 1'b0;
`endif

  assign in_ready = !rst && ((state_q == S_HDR) || (state_q == S_TRAIN) ||
                             (state_q == S_PRG) || (state_q == S_CHR));
  assign w_accept = in_valid && in_ready;

  always_comb begin : p_magic
    case (cnt_q[1:0])
      2'd0:    w_magic = 8'h4E;
      2'd1:    w_magic = 8'h45;
      2'd2:    w_magic = 8'h53;
      default: w_magic = 8'h1A;
    endcase
  end

  assign w_magic_bad = (cnt_q < MAGIC_LEN) && (in_data != w_magic);
  assign w_hdr_last  = (cnt_q == HDR_LAST);
  assign w_prg_bad   = w_prg_exp_bad || (w_prg_units == '0) ||
                       (32'(w_prg_units) > PRG_MAX_UNITS);
  assign w_chr_bad   = w_chr_exp_bad || (32'(w_chr_units) > CHR_MAX_UNITS);

  // Last byte of a section: low bits all ones and the unit index equals
  // units-1, i.e. count == units*unit_size - 1 without a wide multiply.
  assign w_prg_last = (cnt_q[13:0] == 14'h3FFF) &&
                      (32'(cnt_q[CW-1:14]) == 32'(w_prg_units) - 32'd1);
  assign w_chr_last = (cnt_q[12:0] == 13'h1FFF) &&
                      (32'(cnt_q[CW-1:13]) == 32'(w_chr_units) - 32'd1);

  // Mask = next power of two of the unit count, scaled to bytes, minus one.
  always_comb begin : p_masks
    int prg_lg;
    int chr_lg;
    prg_lg     = f_ceil_log2(w_prg_units);
    chr_lg     = f_ceil_log2(w_chr_units);
    w_prg_mask = '0;
    w_chr_mask = '0;
    for (int i = 0; i < PRG_ROM_DEPTH; i++) w_prg_mask[i] = (i < prg_lg + 14);
    for (int i = 0; i < CHR_ROM_DEPTH; i++) w_chr_mask[i] = (i < chr_lg + 13);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_cpu) begin : p_regs
    if (rst) begin
      state_q       <= S_HDR;
      cnt_q         <= '0;
      prg_lo_q      <= '0;
      chr_lo_q      <= '0;
      mir_q         <= 1'b0;
      ram_q         <= 1'b0;
      trn_q         <= 1'b0;
      map_lo_q      <= '0;
      map_hi_q      <= '0;
`ifdef INES_NES2_EN
      nes2_q        <= 1'b0;
      b9_q          <= '0;
      b10_nz_q      <= 1'b0;
`endif
      wr_data_q     <= '0;
      prg_we_q      <= 1'b0;
      chr_we_q      <= 1'b0;
      prg_wr_addr_q <= '0;
      chr_wr_addr_q <= '0;
      mapper_id_q   <= '0;
      mirrorv_q     <= 1'b0;
      prg_ram_q     <= 1'b0;
      chr_ram_q     <= 1'b0;
      prg_mask_q    <= '0;
      chr_mask_q    <= '0;
      prgram_mask_q <= '0;
      loaded_q      <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prg_lo_q      <= prg_lo_d;
      chr_lo_q      <= chr_lo_d;
      mir_q         <= mir_d;
      ram_q         <= ram_d;
      trn_q         <= trn_d;
      map_lo_q      <= map_lo_d;
      map_hi_q      <= map_hi_d;
`ifdef INES_NES2_EN
      nes2_q        <= nes2_d;
      b9_q          <= b9_d;
      b10_nz_q      <= b10_nz_d;
`endif
      wr_data_q     <= wr_data_d;
      prg_we_q      <= prg_we_d;
      chr_we_q      <= chr_we_d;
      prg_wr_addr_q <= prg_wr_addr_d;
      chr_wr_addr_q <= chr_wr_addr_d;
      mapper_id_q   <= mapper_id_d;
      mirrorv_q     <= mirrorv_d;
      prg_ram_q     <= prg_ram_d;
      chr_ram_q     <= chr_ram_d;
      prg_mask_q    <= prg_mask_d;
      chr_mask_q    <= chr_mask_d;
      prgram_mask_q <= prgram_mask_d;
      loaded_q      <= loaded_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, byte counter and header capture
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    prg_lo_d = prg_lo_q;
    chr_lo_d = chr_lo_q;
    mir_d    = mir_q;
    ram_d    = ram_q;
    trn_d    = trn_q;
    map_lo_d = map_lo_q;
    map_hi_d = map_hi_q;
`ifdef INES_NES2_EN
    nes2_d   = nes2_q;
    b9_d     = b9_q;
    b10_nz_d = b10_nz_q;
`endif
    if (w_accept) begin
      case (state_q)
        S_HDR: begin
          cnt_d = cnt_q + 1'b1;
          case (cnt_q[3:0])
            4'd4: prg_lo_d = in_data;
            4'd5: chr_lo_d = in_data;
            4'd6: begin
              mir_d    = in_data[0];
              ram_d    = in_data[1];
              trn_d    = in_data[2];
              map_lo_d = in_data[7:4];
            end
            4'd7: begin
              map_hi_d = in_data[7:4];
`ifdef INES_NES2_EN
              nes2_d   = (in_data[3:2] == 2'b10);
`endif
            end
`ifdef INES_NES2_EN
            4'd9:  b9_d     = in_data;
            4'd10: b10_nz_d = |in_data;
`endif
            default: ;
          endcase
          if (w_magic_bad) begin
            state_d = S_ERR;
            cnt_d   = '0;
          end else if (w_hdr_last) begin
            cnt_d = '0;
            if (w_prg_bad || w_chr_bad) state_d = S_ERR;
            else if (trn_q)             state_d = S_TRAIN;
            else                        state_d = S_PRG;
          end
        end
        S_TRAIN: begin
          if (cnt_q == TRAIN_LAST) begin
            state_d = S_PRG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PRG: begin
          if (w_prg_last) begin
            state_d = (w_chr_units != '0) ? S_CHR : S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CHR: begin
          if (w_chr_last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs: write strobes, configuration and status
  // --------------------------------------------------------------------------
  always_comb begin : p_out
    wr_data_d     = wr_data_q;
    prg_we_d      = 1'b0;
    chr_we_d      = 1'b0;
    prg_wr_addr_d = prg_wr_addr_q;
    chr_wr_addr_d = chr_wr_addr_q;
    mapper_id_d   = mapper_id_q;
    mirrorv_d     = mirrorv_q;
    prg_ram_d     = prg_ram_q;
    chr_ram_d     = chr_ram_q;
    prg_mask_d    = prg_mask_q;
    chr_mask_d    = chr_mask_q;
    prgram_mask_d = prgram_mask_q;
    // DONE is entered on the edge that registers the final strobe, so this
    // raises loaded exactly one cycle after that strobe.
    loaded_d      = (state_q == S_DONE);
    error_d       = error_q;
    err_code_d    = err_code_q;
    if (w_accept) begin
      case (state_q)
        S_HDR: begin
          if (w_magic_bad) begin
            error_d    = 1'b1;
            err_code_d = 2'd1;
          end else if (w_hdr_last) begin
            if (w_prg_bad) begin
              error_d    = 1'b1;
              err_code_d = 2'd2;
            end else if (w_chr_bad) begin
              error_d    = 1'b1;
              err_code_d = 2'd3;
            end else begin
              mapper_id_d   = {map_hi_q, map_lo_q};
              mirrorv_d     = mir_q;
              prg_ram_d     = ram_q | w_prg_ram_ext;
              chr_ram_d     = (w_chr_units == '0);
              prg_mask_d    = w_prg_mask;
              chr_mask_d    = w_chr_mask;
              prgram_mask_d = '1;
            end
          end
        end
        S_PRG: begin
          prg_we_d      = 1'b1;
          wr_data_d     = in_data;
          prg_wr_addr_d = cnt_q[PRG_ROM_DEPTH-1:0];
        end
        S_CHR: begin
          chr_we_d      = 1'b1;
          wr_data_d     = in_data;
          chr_wr_addr_d = cnt_q[CHR_ROM_DEPTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign wr_data     = wr_data_q;
  assign prg_we      = prg_we_q;
  assign chr_we      = chr_we_q;
  assign prg_wr_addr = prg_wr_addr_q;
  assign chr_wr_addr = chr_wr_addr_q;
  assign mapper_id   = mapper_id_q;
  assign mirrorv     = mirrorv_q;
  assign prg_ram     = prg_ram_q;
  assign chr_ram     = chr_ram_q;
  assign prg_mask    = prg_mask_q;
  assign chr_mask    = chr_mask_q;
  assign prgram_mask = prgram_mask_q;
  assign loaded      = loaded_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule
`default_nettype wire
